// File: rtl/left_iter_if.sv
// Request/response bundle for the iterative left shifter.
// The master side issues the request; the slave side is the shifter itself.
interface left_iter_if;
  logic        i_start;
  logic [15:0] i_in;
  logic [3:0]  i_shAmt;
  logic        i_shftRot;
  logic [15:0] o_out;
  logic        o_busy;
  logic        o_done;

  modport master (
    output i_start, i_in, i_shAmt, i_shftRot,
    input  o_out, o_busy, o_done
  );

  modport slave (
    input  i_start, i_in, i_shAmt, i_shftRot,
    output o_out, o_busy, o_done
  );
endinterface

// File: rtl/left_iter.sv
// Iterative 16-bit left shift/rotate: one bit position per clock, done pulse on completion.
// Shft_Rot = 1 shifts in zeros, 0 rotates bit 15 back into bit 0.
module left_iter (
  input  logic       clk,
  input  logic       rst,
  left_iter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_nextState;
  logic [15:0] r_data;
  logic [3:0]  r_cnt;
  logic        r_mode;
  logic        w_fillBit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // A zero shift amount skips SHIFT entirely so latency stays N+1 edges.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_nextState = (bus.i_shAmt != 4'd0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (r_cnt == 4'd1) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign w_fillBit = r_mode ? 1'b0 : r_data[15];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_data <= 16'h0000;
      r_cnt  <= 4'd0;
      r_mode <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.i_start) begin
            r_data <= bus.i_in;
            r_cnt  <= bus.i_shAmt;
            r_mode <= bus.i_shftRot;
          end
        end
        SHIFT: begin
          r_data <= {r_data[14:0], w_fillBit};
          r_cnt  <= r_cnt - 4'd1;
        end
        default: begin
          r_data <= r_data;
        end
      endcase
    end
  end

  assign bus.o_out  = r_data;
  assign bus.o_busy = (r_state != IDLE);
  assign bus.o_done = (r_state == DONE);

endmodule

// File: doc/left_iter.md
# left_iter

Iterative 16-bit left shift/rotate unit, the left-direction counterpart of the combinational right shifter in the execute stage. It accepts one operand per request, shifts it one bit position per clock for the requested amount, and signals completion with a one-cycle `done` pulse. It serves as a low-area alternative for left shifts and rotates, used by the multicycle execute path that stalls on `busy`.

## Interface
- Parameters: none. Data width is fixed at 16 bits and the shift amount at 4 bits.
- `clk`  in  1  single clock; all state updates on the rising edge
- `rst`  in  1  reset, asynchronous and active-high
- `start`  in  1  request strobe; sampled only in IDLE
- `In`  in  16  operand, captured on the accepted `start` edge
- `ShAmt`  in  4  shift amount 0–15, captured with `In`
- `Shft_Rot`  in  1  1 = logical shift left with zero fill; 0 = rotate left (bit 15 wraps into bit 0). Same polarity as the right shifter.
- `Out`  out  16  result register
- `busy`  out  1  high while a request is in flight (SHIFT or DONE)
- `done`  out  1  one-cycle pulse; `Out` holds the final result in that cycle

## Operation
- Internal state:
  - `data[15:0]`: drives `Out`
  - `cnt[3:0]`: remaining shifts
  - `mode`: captured `Shft_Rot`
  - FSM: IDLE / SHIFT / DONE
- IDLE:
  - On `start` = 1: `data <= In`, `cnt <= ShAmt`, `mode <= Shft_Rot`.
  - Next state is SHIFT if `ShAmt != 0`, otherwise DONE.
  - On `start` = 0: stay in IDLE, `data` holds.
- SHIFT, one step per edge:
  - `mode` = 1: `data <= {data[14:0], 1'b0}`.
  - `mode` = 0: `data <= {data[14:0], data[15]}`.
  - `cnt <= cnt - 1`. When `cnt` == 1 before the edge, next state is DONE.
- DONE:
  - `done` = 1 for exactly one cycle, then return to IDLE.
  - `data` holds.
- `busy` = (state != IDLE). `done` = (state == DONE). Both are decoded from registered state.
- `start` is ignored in SHIFT and DONE; no queuing.
- `In`, `ShAmt` and `Shft_Rot` may change freely after capture without effect.
- `Out` equals `data` at all times. It is intermediate during SHIFT, final in DONE, and held in IDLE until the next accepted `start`.
- `cnt` never wraps: it is only decremented in SHIFT, where `cnt` ≥ 1.

## Timing
- Reset values (applied immediately on `rst` assertion, independent of `clk`): state = IDLE, `data` = 0x0000, `cnt` = 0, `mode` = 0. Hence `Out` = 0x0000, `busy` = 0, `done` = 0.
- `rst` asserted mid-operation aborts the operation. No `done` pulse is produced, and the first `start` after `rst` deasserts is accepted normally.
- Latency: with N = `ShAmt` and edge E0 sampling `start`, `done` is high in the cycle following edge E(N), i.e. N+1 edges after E0. This holds for all N = 0..15.
- `busy` rises in the cycle after E0 and falls in the cycle after `done`.
- Minimum request spacing is N+2 cycles: `start` re-sampled in the cycle following `done` is accepted.

## Test plan
- Shift: `In` = 0x8001, `ShAmt` = 1, `Shft_Rot` = 1 -> `Out` = 0x0002; `done` is high exactly 2 edges after the start edge, and `busy` is high for 2 cycles.
- Rotate: `In` = 0x8001, `ShAmt` = 1, `Shft_Rot` = 0 -> `Out` = 0x0003. Then `In` = 0x1234, `ShAmt` = 15, rotate -> `Out` = 0x091A with `done` 16 edges after start.
- Zero amount: `In` = 0xABCD, `ShAmt` = 0, either mode -> `Out` = 0xABCD; `done` 1 edge after start, with no SHIFT cycles.
- Max shift: `In` = 0xFFFF, `ShAmt` = 15, `Shft_Rot` = 1 -> `Out` = 0x8000. Pulse `start` with `In` = 0x0000 during the operation and change `In`; neither the result nor the timing changes.
- Reset mid-operation: `In` = 0x00FF, `ShAmt` = 8, shift; assert `rst` after 3 shift edges -> `Out` = 0x0000, `busy` = 0 and `done` = 0 immediately, with no `done` pulse. A new request (`In` = 0x0001, `ShAmt` = 4, shift) then yields `Out` = 0x0010.
- Back-to-back: keep `start` high continuously with `ShAmt` = 2 -> requests are accepted every 4 cycles, and each `done` pulse lasts 1 cycle.
